padring_strap_ctl: RTL

Parametrised pad-ring controller for FPGA top-levels, sitting between the board pads and `top_earlgrey`. It samples the debug-select and bootstrap strap pads with a settle-and-lock state machine, then routes the shared debug pads to either JTAG or SPI device. It also synchronises and glitch-filters a configurable number of GPIO inputs. All pad outputs stay tristated until the straps are locked.

---
 rtl/padring_strap_ctl_if.sv | 31 +++
 rtl/padring_strap_ctl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/padring_strap_ctl_if.sv
// Debug pad, JTAG TAP and SPI device signals shared through the padring strap controller.
// master = board/core side, slave = padring_strap_ctl.
interface padring_strap_ctl_if;
  logic [3:0] dbg_pad_i;
  logic       dbg_pad_o;
  logic       dbg_pad_oe_o;
  logic       jtag_tck_o;
  logic       jtag_tms_o;
  logic       jtag_tdi_o;
  logic       jtag_trst_no;
  logic       jtag_tdo_i;
  logic       spi_sck_o;
  logic       spi_csb_o;
  logic       spi_mosi_o;
  logic       spi_miso_i;
  logic       spi_miso_en_i;

  modport master (
    output dbg_pad_i, jtag_tdo_i, spi_miso_i, spi_miso_en_i,
    input  dbg_pad_o, dbg_pad_oe_o,
    input  jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no,
    input  spi_sck_o, spi_csb_o, spi_mosi_o
  );

  modport slave (
    input  dbg_pad_i, jtag_tdo_i, spi_miso_i, spi_miso_en_i,
    output dbg_pad_o, dbg_pad_oe_o,
    output jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_no,
    output spi_sck_o, spi_csb_o, spi_mosi_o
  );
endinterface

// File: rtl/padring_strap_ctl.sv
// Pad-ring controller: strap settle-and-lock FSM, JTAG/SPI debug pad mux, GPIO sync and optional filter.
// Define PADRING_GPIO_FILTER_EN to instantiate the GPIO glitch filter.
module padring_strap_ctl #(
  parameter int unsigned NumGpio     = 16,
  parameter int unsigned StrapSettle = 8,
  parameter int unsigned FiltCycles  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                strap_dbg_i,
  input  logic                strap_boot_i,
  input  logic                strap_resample_i,
  output logic                strap_done_o,
  output logic                strap_spi_o,
  output logic                strap_boot_o,
  padring_strap_ctl_if.slave  dbg,
  input  logic [NumGpio-1:0]  gpio_pad_i,
  output logic [NumGpio-1:0]  gpio_in_o,
  input  logic [NumGpio-1:0]  gpio_out_i,
  input  logic [NumGpio-1:0]  gpio_oe_i,
  output logic [NumGpio-1:0]  gpio_pad_o,
  output logic [NumGpio-1:0]  gpio_pad_oe_o
);

  if (NumGpio < 1 || NumGpio > 32 || StrapSettle < 2 || StrapSettle > 255 ||
      FiltCycles < 1 || FiltCycles > 255) begin : g_param_check
    $error("padring_strap_ctl: parameter out of range");
  end

  localparam int unsigned CntW = $clog2(StrapSettle);

  typedef enum logic [1:0] {
    FILL,
    SAMPLE,
    LOCKED
  } state_e;

  state_e          state;
  logic [1:0]      fill_cnt;
  logic [CntW-1:0] cnt;
  logic [1:0]      prev;
  logic [1:0]      strap_s1;
  logic [1:0]      strap_s2;

  // Synced straps are packed {dbg, boot}; done doubles as the LOCKED indicator for the muxes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      strap_s1     <= '0;
      strap_s2     <= '0;
      state        <= FILL;
      fill_cnt     <= '0;
      cnt          <= '0;
      prev         <= '0;
      strap_done_o <= 1'b0;
      strap_spi_o  <= 1'b0;
      strap_boot_o <= 1'b0;
    end else begin
      strap_s1 <= {strap_dbg_i, strap_boot_i};
      strap_s2 <= strap_s1;
      case (state)
        FILL: begin
          if (fill_cnt == 2'd2) begin
            state <= SAMPLE;
            prev  <= strap_s2;
            cnt   <= '0;
          end else begin
            fill_cnt <= fill_cnt + 2'd1;
          end
        end
        SAMPLE: begin
          if (strap_s2 != prev) begin
            cnt  <= '0;
            prev <= strap_s2;
          end else if (cnt == CntW'(StrapSettle - 1)) begin
            if (strap_resample_i) begin
              cnt <= '0;
            end else begin
              state        <= LOCKED;
              strap_done_o <= 1'b1;
              strap_spi_o  <= prev[1];
              strap_boot_o <= prev[0];
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        LOCKED: begin
          if (strap_resample_i) begin
            state        <= SAMPLE;
            cnt          <= '0;
            prev         <= strap_s2;
            strap_done_o <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // TCK passes straight through the mux; nothing on the debug path is registered.
  always_comb begin
    dbg.jtag_tck_o   = 1'b0;
    dbg.jtag_tms_o   = 1'b1;
    dbg.jtag_tdi_o   = 1'b0;
    dbg.jtag_trst_no = 1'b0;
    dbg.spi_sck_o    = 1'b0;
    dbg.spi_csb_o    = 1'b1;
    dbg.spi_mosi_o   = 1'b0;
    dbg.dbg_pad_o    = 1'b0;
    dbg.dbg_pad_oe_o = 1'b0;
    if (strap_done_o) begin
      if (strap_spi_o) begin
        dbg.spi_sck_o    = dbg.dbg_pad_i[0];
        dbg.spi_csb_o    = dbg.dbg_pad_i[1];
        dbg.spi_mosi_o   = dbg.dbg_pad_i[2];
        dbg.dbg_pad_o    = dbg.spi_miso_i;
        dbg.dbg_pad_oe_o = dbg.spi_miso_en_i;
      end else begin
        dbg.jtag_tck_o   = dbg.dbg_pad_i[0];
        dbg.jtag_tms_o   = dbg.dbg_pad_i[1];
        dbg.jtag_tdi_o   = dbg.dbg_pad_i[2];
        dbg.jtag_trst_no = dbg.dbg_pad_i[3];
        dbg.dbg_pad_o    = dbg.jtag_tdo_i;
        dbg.dbg_pad_oe_o = 1'b1;
      end
    end
  end

  assign gpio_pad_o    = gpio_out_i;
  assign gpio_pad_oe_o = strap_done_o ? gpio_oe_i : '0;

  logic [NumGpio-1:0] gpio_s1;
  logic [NumGpio-1:0] gpio_s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gpio_s1 <= '0;
      gpio_s2 <= '0;
    end else begin
      gpio_s1 <= gpio_pad_i;
      gpio_s2 <= gpio_s1;
    end
  end

`ifdef PADRING_GPIO_FILTER_EN
  localparam int unsigned FiltW = $clog2(FiltCycles + 1);

  logic [FiltW-1:0]   filt_cnt [NumGpio];
  logic [NumGpio-1:0] gpio_filt;

  // Counter tracks consecutive disagreeing cycles; it clears on toggle, so it never passes FiltCycles-1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gpio_filt <= '0;
      for (int unsigned i = 0; i < NumGpio; i++) begin
        filt_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumGpio; i++) begin
        if (gpio_s2[i] == gpio_filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] >= FiltW'(FiltCycles - 1)) begin
          gpio_filt[i] <= gpio_s2[i];
          filt_cnt[i]  <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + FiltW'(1);
        end
      end
    end
  end

  assign gpio_in_o = gpio_filt;
`else
  assign gpio_in_o = gpio_s2;
`endif

endmodule
